// File: rtl/control_sram.sv
// Write/read-back SRAM checker: writes Cuenta words of an incrementing pattern
// starting at Dir_ini, reads them back and counts mismatches (saturating).
module control_sram #(
    parameter int ANCHO_DIR  = 8,
    parameter int ANCHO_DATO = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Inicio,
    input  logic [ANCHO_DIR-1:0]  Dir_ini,
    input  logic [ANCHO_DIR-1:0]  Cuenta,
    input  logic [ANCHO_DATO-1:0] Dato_base,
    input  logic [ANCHO_DATO-1:0] Dato_s,
    output logic [ANCHO_DIR-1:0]  Dir,
    output logic [ANCHO_DATO-1:0] Dato_e,
    output logic                  We,
    output logic                  En,
    output logic                  Ocupado,
    output logic                  Listo,
    output logic [ANCHO_DATO-1:0] Num_err,
    output logic                  Error
);

    typedef enum logic [1:0] {REPOSO, ESCRIBE, LEE, FIN} estado_t;

    estado_t               estado, estado_d;
    logic [ANCHO_DIR-1:0]  indice, indice_d;
    logic [ANCHO_DIR-1:0]  dir_base, dir_base_d;
    logic [ANCHO_DIR-1:0]  cuenta_r, cuenta_d;
    logic [ANCHO_DATO-1:0] base_r, base_d;
    logic [ANCHO_DATO-1:0] patron, patron_d;
    logic [ANCHO_DIR-1:0]  dir_d;
    logic [ANCHO_DATO-1:0] dato_d;
    logic [ANCHO_DATO-1:0] num_err_d;
    logic                  we_d, en_d;
    logic                  ultimo;

    assign ultimo  = (indice == cuenta_r - 1'b1);
    assign Ocupado = (estado != REPOSO);
    assign Listo   = (estado == FIN);
    assign Error   = |Num_err;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            estado   <= REPOSO;
            indice   <= '0;
            dir_base <= '0;
            cuenta_r <= '0;
            base_r   <= '0;
            patron   <= '0;
            Dir      <= '0;
            Dato_e   <= '0;
            We       <= 1'b0;
            En       <= 1'b0;
            Num_err  <= '0;
        end else begin
            estado   <= estado_d;
            indice   <= indice_d;
            dir_base <= dir_base_d;
            cuenta_r <= cuenta_d;
            base_r   <= base_d;
            patron   <= patron_d;
            Dir      <= dir_d;
            Dato_e   <= dato_d;
            We       <= we_d;
            En       <= en_d;
            Num_err  <= num_err_d;
        end
    end

    // Outputs are computed one cycle ahead so the SRAM sees registered signals.
    always_comb begin
        estado_d   = estado;
        indice_d   = indice;
        dir_base_d = dir_base;
        cuenta_d   = cuenta_r;
        base_d     = base_r;
        patron_d   = patron;
        dir_d      = Dir;
        dato_d     = Dato_e;
        we_d       = 1'b0;
        en_d       = 1'b0;
        num_err_d  = Num_err;

        case (estado)
            REPOSO: begin
                if (Inicio) begin
                    dir_base_d = Dir_ini;
                    cuenta_d   = Cuenta;
                    base_d     = Dato_base;
                    indice_d   = '0;
                    num_err_d  = '0;
                    if (Cuenta == '0) begin
                        estado_d = FIN;
                    end else begin
                        estado_d = ESCRIBE;
                        en_d     = 1'b1;
                        we_d     = 1'b1;
                        dir_d    = Dir_ini;
                        dato_d   = Dato_base;
                    end
                end
            end
            ESCRIBE: begin
                en_d = 1'b1;
                if (ultimo) begin
                    estado_d = LEE;
                    indice_d = '0;
                    dir_d    = dir_base;
                    patron_d = base_r;
                end else begin
                    we_d     = 1'b1;
                    indice_d = indice + 1'b1;
                    dir_d    = Dir + 1'b1;
                    dato_d   = Dato_e + 1'b1;
                end
            end
            LEE: begin
                if ((Dato_s != patron) && (Num_err != '1))
                    num_err_d = Num_err + 1'b1;
                if (ultimo) begin
                    estado_d = FIN;
                end else begin
                    en_d     = 1'b1;
                    indice_d = indice + 1'b1;
                    dir_d    = Dir + 1'b1;
                    patron_d = patron + 1'b1;
                end
            end
            FIN: begin
                estado_d = REPOSO;
            end
            default: estado_d = REPOSO;
        endcase
    end

endmodule

// File: tb/tb_control_sram.sv
// Directed bench for control_sram with a behavioural SRAM model; a second
// instance with 4-bit data exercises Num_err saturation.
module tb_control_sram;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Inicio;
    logic [7:0] Dir_ini, Cuenta, Dato_base, Dato_s;
    logic [7:0] Dir, Dato_e, Num_err;
    logic       We, En, Ocupado, Listo, Error;

    logic       Inicio_4;
    logic [7:0] Cuenta_4, Dir_4;
    logic [3:0] Dato_base_4, Dato_e_4, Num_err_4;
    logic       We_4, En_4, Ocupado_4, Listo_4, Error_4;

    int checks = 0;
    int errors = 0;
    int modo   = 0;   // 0 ideal, 1 address 5 reads 0, 2 every read 0

    logic [7:0] mem [256];

    always #5 Clk = ~Clk;

    control_sram #(.ANCHO_DIR(8), .ANCHO_DATO(8)) dut (
        .Clk(Clk), .Rst(Rst), .Inicio(Inicio), .Dir_ini(Dir_ini), .Cuenta(Cuenta),
        .Dato_base(Dato_base), .Dato_s(Dato_s), .Dir(Dir), .Dato_e(Dato_e),
        .We(We), .En(En), .Ocupado(Ocupado), .Listo(Listo), .Num_err(Num_err), .Error(Error)
    );

    control_sram #(.ANCHO_DIR(8), .ANCHO_DATO(4)) dut_4 (
        .Clk(Clk), .Rst(Rst), .Inicio(Inicio_4), .Dir_ini(8'd0), .Cuenta(Cuenta_4),
        .Dato_base(Dato_base_4), .Dato_s(4'd0), .Dir(Dir_4), .Dato_e(Dato_e_4),
        .We(We_4), .En(En_4), .Ocupado(Ocupado_4), .Listo(Listo_4), .Num_err(Num_err_4), .Error(Error_4)
    );

    always @(posedge Clk) if (En && We) mem[Dir] <= Dato_e;

    assign Dato_s = !(En && !We)             ? 8'h00 :
                    (modo == 2)              ? 8'h00 :
                    (modo == 1 && Dir == 5)  ? 8'h00 : mem[Dir];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [7:0] d0, input logic [7:0] n,
                       input logic [7:0] b, input logic [7:0] exp_err);
        int nn;
        logic [7:0] a, d;
        nn = int'(n);
        @(negedge Clk);
        Dir_ini = d0; Cuenta = n; Dato_base = b; Inicio = 1'b1;
        @(posedge Clk); #1;
        Inicio = 1'b0;
        for (int c = 1; c <= 2*nn + 1; c++) begin
            if (c > 1) begin @(posedge Clk); #1; end
            if (c <= nn) begin
                a = d0 + 8'(c - 1);
                d = b + 8'(c - 1);
                check($sformatf("%s wr%0d", tag, c - 1), 32'({En, We, Ocupado, Listo, Dir, Dato_e}),
                      32'({4'b1110, a, d}));
            end else if (c <= 2*nn) begin
                a = d0 + 8'(c - nn - 1);
                check($sformatf("%s rd%0d", tag, c - nn - 1), 32'({En, We, Ocupado, Listo, Dir}),
                      32'({4'b1010, a}));
            end else begin
                check({tag, " fin"}, 32'({En, We, Ocupado, Listo}), 32'(4'b0011));
                check({tag, " num_err"}, 32'({Error, Num_err}), 32'({exp_err != 0, exp_err}));
            end
        end
        @(posedge Clk); #1;
        check({tag, " idle"}, 32'({En, We, Ocupado, Listo, Error, Num_err}),
              32'({4'b0000, exp_err != 0, exp_err}));
    endtask

    initial begin
        int lat;
        Rst = 1'b1; Inicio = 1'b0; Dir_ini = '0; Cuenta = '0; Dato_base = '0;
        Inicio_4 = 1'b0; Cuenta_4 = '0; Dato_base_4 = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset", 32'({Dir, Dato_e, We, En, Ocupado, Listo, Num_err, Error}), 32'd0);
        @(negedge Clk); Rst = 1'b0;

        modo = 0; run("ideal", 8'd0, 8'd12, 8'd200, 8'd0);
        modo = 1; run("corrupt5", 8'd0, 8'd12, 8'd200, 8'd1);
        modo = 0; run("cuenta0", 8'd7, 8'd0, 8'd9, 8'd0);
        run("wrap", 8'd250, 8'd10, 8'd254, 8'd0);
        modo = 2; run("zeros1", 8'd0, 8'd255, 8'd1, 8'd255);
        run("zeros2", 8'd0, 8'd255, 8'd1, 8'd255);
        modo = 0;

        // Reset during the third write with Inicio held high throughout.
        @(negedge Clk);
        Dir_ini = 8'd16; Cuenta = 8'd12; Dato_base = 8'd40; Inicio = 1'b1;
        @(posedge Clk); #1;
        Dir_ini = 8'd99; Dato_base = 8'd77;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        check("rst wr2", 32'({En, We, Ocupado, Dir, Dato_e}), 32'({3'b111, 8'd18, 8'd42}));
        Rst = 1'b1;
        @(posedge Clk); #1;
        check("rst abort", 32'({Dir, Dato_e, We, En, Ocupado, Listo, Num_err, Error}), 32'd0);
        Rst = 1'b0; Inicio = 1'b0;
        @(posedge Clk); #1;
        check("rst no resume", 32'({En, We, Ocupado, Listo}), 32'd0);

        // Saturation on the 4-bit instance: 19 mismatches clip to 15.
        @(negedge Clk);
        Cuenta_4 = 8'd20; Dato_base_4 = 4'd1; Inicio_4 = 1'b1;
        @(posedge Clk); #1;
        Inicio_4 = 1'b0;
        lat = 1;
        while (!Listo_4 && lat < 100) begin
            @(posedge Clk); #1;
            lat++;
        end
        check("sat latency", 32'(lat), 32'd41);
        check("sat num_err", 32'({Error_4, Num_err_4}), 32'({1'b1, 4'd15}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
